// File: rtl/midi_note_tracker.sv
// MIDI byte-stream parser with a last-note-priority stack of held keys for one channel.
// Drives monophonic note, velocity and gate; note_changed pulses when any of them changes.
//
// state | meaning
// IDLE  | no running status, data bytes ignored
// D1    | running status valid, awaiting first data byte
// D2    | first data byte stored, awaiting second data byte
module midi_note_tracker #(
  parameter int MIDI_NOTES   = 128,
  parameter int STACK_DEPTH  = 8,
  parameter int MIDI_CHANNEL = 0,
  parameter int OMNI         = 0,
  localparam int NW          = $clog2(MIDI_NOTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output logic [NW-1:0] note,
  output logic [6:0]    velocity,
  output logic          gate,
  output logic          note_changed
);

  localparam logic [3:0] CHAN = 4'(MIDI_CHANNEL);

  typedef enum logic [1:0] {IDLE, D1, D2} state_t;

  state_t     state;
  logic [7:0] status;
  logic [6:0] d1;

  // Entry 0 is the most recent key; valid is a contiguous run of ones from bit 0.
  logic [NW-1:0]          stk_note [STACK_DEPTH];
  logic [6:0]             stk_vel  [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] valid;

  logic [NW-1:0]          n_note [STACK_DEPTH];
  logic [6:0]             n_vel  [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] n_valid;
  logic [STACK_DEPTH-1:0] hit, hit_le, hit_ge;

  logic          complete, chan_ok, note_ok, found;
  logic          ev_on, ev_off, ev_alloff;
  logic [NW-1:0] key;
  logic [6:0]    vel_in;
  logic [NW-1:0] nx_note;
  logic [6:0]    nx_vel;
  logic          nx_gate;

  assign key      = d1[NW-1:0];
  assign vel_in   = rx_byte[6:0];
  assign complete = rx_valid && !rx_byte[7] && (state == D2);
  assign chan_ok  = (OMNI != 0) || (status[3:0] == CHAN);
  assign note_ok  = ({25'd0, d1} < MIDI_NOTES);

  assign ev_on     = complete && chan_ok && note_ok && (status[7:4] == 4'h9) && (vel_in != 7'd0);
  assign ev_off    = complete && chan_ok && note_ok &&
                     ((status[7:4] == 4'h8) || ((status[7:4] == 4'h9) && (vel_in == 7'd0)));
  assign ev_alloff = complete && chan_ok && (status[7:4] == 4'hB) && (d1 == 7'h7B);

  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) hit[i] = valid[i] && (stk_note[i] == key);
    hit_le = '0;
    hit_ge = '0;
    hit_le[0] = hit[0];
    for (int i = 1; i < STACK_DEPTH; i++) hit_le[i] = hit_le[i-1] | hit[i];
    hit_ge[STACK_DEPTH-1] = hit[STACK_DEPTH-1];
    for (int i = STACK_DEPTH-2; i >= 0; i--) hit_ge[i] = hit_ge[i+1] | hit[i];
    found = hit_le[STACK_DEPTH-1];

    n_note  = stk_note;
    n_vel   = stk_vel;
    n_valid = valid;
    if (ev_on) begin
      // Shift down everything above the old copy of the key (or all, if absent).
      for (int i = 1; i < STACK_DEPTH; i++) begin
        if (!found || hit_ge[i]) begin
          n_note[i] = stk_note[i-1];
          n_vel[i]  = stk_vel[i-1];
        end
      end
      n_note[0] = key;
      n_vel[0]  = vel_in;
      if (!found) n_valid = {valid[STACK_DEPTH-2:0], 1'b1};
    end else if (ev_off && found) begin
      for (int i = 0; i < STACK_DEPTH-1; i++) begin
        if (hit_le[i]) begin
          n_note[i] = stk_note[i+1];
          n_vel[i]  = stk_vel[i+1];
        end
      end
      n_valid = {1'b0, valid[STACK_DEPTH-1:1]};
    end else if (ev_alloff) begin
      n_valid = '0;
    end

    nx_gate = |n_valid;
    nx_note = nx_gate ? n_note[0] : note;
    nx_vel  = nx_gate ? n_vel[0]  : velocity;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      status       <= '0;
      d1           <= '0;
      valid        <= '0;
      note         <= '0;
      velocity     <= '0;
      gate         <= 1'b0;
      note_changed <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_note[i] <= '0;
        stk_vel[i]  <= '0;
      end
    end else begin
      if (rx_valid) begin
        if (rx_byte[7]) begin
          if (rx_byte < 8'hF0) begin
            status <= rx_byte;
            state  <= D1;
          end else if (rx_byte < 8'hF8) begin
            state <= IDLE;
          end
        end else begin
          case (state)
            D1: begin
              // Cn/Dn carry a single data byte: complete and drop, stay in D1.
              if (status[7:5] != 3'b110) begin
                d1    <= rx_byte[6:0];
                state <= D2;
              end
            end
            D2:      state <= D1;
            default: state <= IDLE;
          endcase
        end
      end
      stk_note     <= n_note;
      stk_vel      <= n_vel;
      valid        <= n_valid;
      note         <= nx_note;
      velocity     <= nx_vel;
      gate         <= nx_gate;
      note_changed <= {nx_note, nx_vel, nx_gate} != {note, velocity, gate};
    end
  end

endmodule

// File: tb/tb_midi_note_tracker.sv
// Directed-vector bench for midi_note_tracker: a default instance (channel 0, depth 8)
// and an OMNI instance with a 64-note range, both fed the same byte stream.
module tb_midi_note_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  logic [6:0] note0, vel0;
  logic       gate0, nc0;
  logic [5:0] note1;
  logic [6:0] vel1;
  logic       gate1, nc1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  midi_note_tracker u0 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .note(note0), .velocity(vel0), .gate(gate0), .note_changed(nc0)
  );

  midi_note_tracker #(.MIDI_NOTES(64), .OMNI(1)) u1 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .note(note1), .velocity(vel1), .gate(gate1), .note_changed(nc1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns #1 after the edge that consumed it.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_note", note0, 0);
    check("rst_vel", vel0, 0);
    check("rst_gate", gate0, 0);
    check("rst_nc", nc0, 0);

    // basic note on
    send(8'h90); send(8'h3C);
    check("on_partial_gate", gate0, 0);
    send(8'h64);
    check("on_note", note0, 60);
    check("on_vel", vel0, 100);
    check("on_gate", gate0, 1);
    check("on_nc", nc0, 1);
    idle();
    check("on_nc_drop", nc0, 0);
    check("on_note_hold", note0, 60);

    // running status
    send(8'h40); send(8'h50);
    check("rs_note", note0, 64);
    check("rs_vel", vel0, 80);
    check("rs_nc", nc0, 1);
    send(8'h3C); send(8'h00);
    check("rs_off_lower_note", note0, 64);
    check("rs_off_lower_gate", gate0, 1);
    check("rs_off_lower_nc", nc0, 0);
    send(8'h40); send(8'h00);
    check("rs_alloff_gate", gate0, 0);
    check("rs_alloff_note", note0, 64);
    check("rs_alloff_nc", nc0, 1);
    send(8'h40); send(8'h50);
    check("repress_gate", gate0, 1);
    check("repress_nc", nc0, 1);
    send(8'h40); send(8'h50);
    check("same_top_nc", nc0, 0);
    check("same_top_note", note0, 64);
    send(8'h40); send(8'h00);
    check("repress_off_gate", gate0, 0);

    // stack overflow and ordered release; velocity = key - 0x20
    do_reset();
    send(8'h90);
    for (int k = 8'h30; k <= 8'h38; k++) begin
      send(8'(k)); send(8'(k - 8'h20));
    end
    check("full_note", note0, 8'h38);
    check("full_vel", vel0, 8'h18);
    for (int k = 8'h38; k >= 8'h31; k--) begin
      send(8'(k)); send(8'h00);
      if (k > 8'h31) begin
        check($sformatf("rel_%0h_note", k), note0, k - 1);
        check($sformatf("rel_%0h_vel", k), vel0, k - 1 - 8'h20);
        check($sformatf("rel_%0h_gate", k), gate0, 1);
      end else begin
        check("rel_last_gate", gate0, 0);
        check("rel_last_note", note0, 8'h31);
      end
    end
    send(8'h30); send(8'h00);
    check("discarded_off_gate", gate0, 0);
    check("discarded_off_note", note0, 8'h31);
    check("discarded_off_nc", nc0, 0);

    // channel filter vs OMNI
    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    check("ch1_u0_gate", gate0, 0);
    check("ch1_u0_nc", nc0, 0);
    check("ch1_omni_note", note1, 60);
    check("ch1_omni_gate", gate1, 1);
    check("ch1_omni_vel", vel1, 100);

    // real-time byte, sysex clear, all notes off, 8n note off
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    check("rt_note", note0, 60);
    check("rt_gate", gate0, 1);
    send(8'hF0); send(8'h3E); send(8'h64);
    check("sysex_note", note0, 60);
    send(8'h90); send(8'h3E); send(8'h70);
    check("second_note", note0, 62);
    check("second_vel", vel0, 112);
    send(8'hB0); send(8'h7B); send(8'h00);
    check("alloff_gate", gate0, 0);
    check("alloff_note", note0, 62);
    send(8'h90); send(8'h3C); send(8'h01);
    check("post_alloff_note", note0, 60);
    check("post_alloff_vel", vel0, 1);
    send(8'h80); send(8'h3C); send(8'h40);
    check("8n_off_gate", gate0, 0);
    send(8'hC0); send(8'h3C); send(8'h64);
    check("cn_drop_gate", gate0, 0);

    // reset mid-message
    do_reset();
    send(8'h90); send(8'h3C);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    send(8'h64);
    check("midrst_gate", gate0, 0);
    check("midrst_note", note0, 0);
    check("midrst_nc", nc0, 0);
    idle();
    check("midrst_nc2", nc0, 0);

    // note range limit on the 64-note instance
    do_reset();
    send(8'h90); send(8'h40); send(8'h64);
    check("range_u0_note", note0, 64);
    check("range_u1_gate", gate1, 0);
    send(8'h3F); send(8'h64);
    check("range_u1_note", note1, 63);
    check("range_u1_gate2", gate1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
